// File: rtl/exe_trace_fifo.sv
// exe_trace_fifo
//   Captures one {PC, IR, seq} record per retired instruction (exe_enable)
//   into a circular FIFO and presents the head record on a valid/ready stream.
//   When the FIFO is full, records are dropped rather than stalling the core.
//   Drops are counted in a saturating counter and latched in a sticky flag.
//
// Ports
//   clk, reset_n          clock, async active-low reset
//   sync_clear            synchronous flush of FIFO, counters and sticky flag
//   trace_enable          capture gate
//   exe_enable            retire strobe
//   PC_in, IR_in          retiring instruction PC / word
//   out_valid, out_ready  head record handshake
//   out_pc/out_ir/out_seq head record fields (registered, first-word-fall-through)
//   fill_level            stored records, 0..2^DEPTH_LOG2
//   drop_count            saturating count of dropped records
//   overflow              sticky, set on first drop
module exe_trace_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int PC_WIDTH   = 32,
  parameter int IR_WIDTH   = 32,
  parameter int SEQ_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sync_clear,
  input  logic                  trace_enable,
  input  logic                  exe_enable,
  input  logic [PC_WIDTH-1:0]   PC_in,
  input  logic [IR_WIDTH-1:0]   IR_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PC_WIDTH-1:0]   out_pc,
  output logic [IR_WIDTH-1:0]   out_ir,
  output logic [SEQ_WIDTH-1:0]  out_seq,
  output logic [DEPTH_LOG2:0]   fill_level,
  output logic [15:0]           drop_count,
  output logic                  overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef struct packed {
    logic [PC_WIDTH-1:0]  pc;
    logic [IR_WIDTH-1:0]  ir;
    logic [SEQ_WIDTH-1:0] seq;
  } rec_t;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   lvl_t;

  // Storage: no reset so it maps onto MLAB/M9K.
  rec_t mem [DEPTH];

  ptr_t               wr_ptr_q, wr_ptr_d;
  ptr_t               rd_ptr_q, rd_ptr_d;
  lvl_t               fill_level_q, fill_level_d;
  logic [SEQ_WIDTH-1:0] seq_q, seq_d;
  logic [15:0]        drop_count_q, drop_count_d;
  logic               overflow_q, overflow_d;
  rec_t               head_q, head_d;

  logic push_req, pop, full, accept, drop, head_new, wr_en;
  rec_t new_rec;

  always_comb begin
    push_req = exe_enable & trace_enable;
    pop      = (fill_level_q != '0) & out_ready;
    full     = (fill_level_q == lvl_t'(DEPTH));
    // Full-with-pop frees the head slot in the same cycle, so the push fits.
    accept   = push_req & (~full | pop);
    drop     = push_req & ~accept;
    wr_en    = accept & ~sync_clear;

    new_rec.pc  = PC_in;
    new_rec.ir  = IR_in;
    new_rec.seq = seq_q;

    wr_ptr_d = wr_ptr_q + ptr_t'(accept);
    rd_ptr_d = rd_ptr_q + ptr_t'(pop);

    fill_level_d = fill_level_q;
    case ({accept, pop})
      2'b10:   fill_level_d = fill_level_q + lvl_t'(1);
      2'b01:   fill_level_d = fill_level_q - lvl_t'(1);
      default: fill_level_d = fill_level_q;
    endcase

    // Stored and dropped records both consume a sequence number.
    seq_d = seq_q + SEQ_WIDTH'(push_req);

    drop_count_d = drop_count_q;
    if (drop && drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
    overflow_d = overflow_q | drop;

    // The next head is the incoming record when nothing else remains after
    // this cycle's pop; the array write has not landed yet, so bypass it.
    head_new = accept & ((fill_level_q == '0) | ((fill_level_q == lvl_t'(1)) & pop));

    head_d = head_q;
    if (head_new)                 head_d = new_rec;
    else if (fill_level_d != '0)  head_d = mem[rd_ptr_d];

    if (sync_clear) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      fill_level_d = '0;
      seq_d        = '0;
      drop_count_d = '0;
      overflow_d   = 1'b0;
      head_d       = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fill_level_q <= '0;
      seq_q        <= '0;
      drop_count_q <= '0;
      overflow_q   <= 1'b0;
      head_q       <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fill_level_q <= fill_level_d;
      seq_q        <= seq_d;
      drop_count_q <= drop_count_d;
      overflow_q   <= overflow_d;
      head_q       <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= new_rec;
  end

  assign out_valid  = (fill_level_q != '0);
  assign out_pc     = head_q.pc;
  assign out_ir     = head_q.ir;
  assign out_seq    = head_q.seq;
  assign fill_level = fill_level_q;
  assign drop_count = drop_count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_exe_trace_fifo.sv
module tb_exe_trace_fifo;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sync_clear;
  logic        trace_enable;
  logic        exe_enable;
  logic [31:0] PC_in;
  logic [31:0] IR_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_ir;
  logic [15:0] out_seq;
  logic [4:0]  fill_level;
  logic [15:0] drop_count;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  exe_trace_fifo dut (
    .clk(clk), .reset_n(reset_n), .sync_clear(sync_clear),
    .trace_enable(trace_enable), .exe_enable(exe_enable),
    .PC_in(PC_in), .IR_in(IR_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_ir(out_ir), .out_seq(out_seq),
    .fill_level(fill_level), .drop_count(drop_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are set before the edge; outputs are sampled 1 time unit after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cycle();
    exe_enable = 1'b0;
    sync_clear = 1'b1;
    cyc();
    sync_clear = 1'b0;
  endtask

  initial begin
    logic [31:0] h_pc, h_ir;
    logic [15:0] h_seq;
    int e;

    reset_n = 1'b0; sync_clear = 1'b0; trace_enable = 1'b0; exe_enable = 1'b0;
    PC_in = '0; IR_in = '0; out_ready = 1'b0;
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_fill", fill_level, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_seq", out_seq, 0);
    reset_n = 1'b1;
    cyc();

    // Single record through an empty FIFO, consumer ready.
    trace_enable = 1'b1; out_ready = 1'b1;
    exe_enable = 1'b1; PC_in = 32'h0; IR_in = 32'h93;
    cyc();
    exe_enable = 1'b0;
    chk("single_valid", out_valid, 1);
    chk("single_pc", out_pc, 32'h0);
    chk("single_ir", out_ir, 32'h93);
    chk("single_seq", out_seq, 0);
    cyc();
    chk("single_drain_valid", out_valid, 0);
    chk("single_drain_fill", fill_level, 0);

    // Fill to 16, drop the 17th, then full-with-pop, then drain.
    clear_cycle();
    out_ready = 1'b0;
    for (int k = 0; k < 17; k++) begin
      exe_enable = 1'b1; PC_in = 32'h8000_0000 + 4 * k; IR_in = k;
      cyc();
      if (k == 15) begin
        chk("full_fill", fill_level, 16);
        chk("full_drop", drop_count, 0);
      end
    end
    chk("drop_fill", fill_level, 16);
    chk("drop_count", drop_count, 1);
    chk("drop_ovf", overflow, 1);
    chk("drop_head_seq", out_seq, 0);
    chk("drop_head_pc", out_pc, 32'h8000_0000);
    // Full with simultaneous pop: record (seq 17) accepted.
    exe_enable = 1'b1; PC_in = 32'h8000_0000 + 4 * 17; IR_in = 17; out_ready = 1'b1;
    cyc();
    exe_enable = 1'b0;
    chk("fwp_fill", fill_level, 16);
    chk("fwp_drop", drop_count, 1);
    chk("fwp_head_seq", out_seq, 1);
    for (int k = 0; k < 16; k++) begin
      int s;
      s = (k < 15) ? k + 1 : 17;
      chk("drain_valid", out_valid, 1);
      chk("drain_fill", fill_level, 16 - k);
      chk("drain_seq", out_seq, s);
      chk("drain_pc", out_pc, 32'h8000_0000 + 4 * s);
      chk("drain_ir", out_ir, s);
      cyc();
    end
    chk("drained_valid", out_valid, 0);
    chk("drained_fill", fill_level, 0);

    // Backpressure: ready toggles every cycle with 3 records buffered.
    clear_cycle();
    chk("clr_drop", drop_count, 0);
    chk("clr_ovf", overflow, 0);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exe_enable = 1'b1; PC_in = 32'h100 + 4 * k; IR_in = 32'hA0 + k;
      cyc();
    end
    exe_enable = 1'b0;
    chk("bp_fill", fill_level, 3);
    e = 0;
    for (int c = 0; c < 10; c++) begin
      out_ready = c[0];
      if (!out_ready) begin
        h_pc = out_pc; h_ir = out_ir; h_seq = out_seq;
        cyc();
        if (out_valid) begin
          chk("bp_hold_pc", out_pc, h_pc);
          chk("bp_hold_ir", out_ir, h_ir);
          chk("bp_hold_seq", out_seq, h_seq);
        end
      end else begin
        if (out_valid) begin
          chk("bp_seq", out_seq, e);
          chk("bp_pc", out_pc, 32'h100 + 4 * e);
          e++;
        end
        cyc();
      end
    end
    chk("bp_count", e, 3);
    chk("bp_empty", out_valid, 0);

    // trace_enable low: retires are neither stored nor dropped.
    clear_cycle();
    out_ready = 1'b0; trace_enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      exe_enable = 1'b1; PC_in = 32'h200 + 4 * k; IR_in = k;
      cyc();
    end
    chk("te_off_fill", fill_level, 0);
    chk("te_off_drop", drop_count, 0);
    trace_enable = 1'b1; PC_in = 32'h300; IR_in = 32'h33;
    cyc();
    exe_enable = 1'b0;
    chk("te_on_valid", out_valid, 1);
    chk("te_on_seq", out_seq, 0);
    chk("te_on_pc", out_pc, 32'h300);
    chk("te_on_drop", drop_count, 0);

    // Async reset mid-drain.
    clear_cycle();
    for (int k = 0; k < 8; k++) begin
      exe_enable = 1'b1; PC_in = 32'h400 + 4 * k; IR_in = k;
      cyc();
    end
    exe_enable = 1'b0;
    chk("pre_rst_fill", fill_level, 8);
    out_ready = 1'b1;
    cyc();
    #3 reset_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_fill", fill_level, 0);
    chk("arst_drop", drop_count, 0);
    #2 reset_n = 1'b1;
    out_ready = 1'b0;
    exe_enable = 1'b1; PC_in = 32'h500; IR_in = 32'h55;
    cyc();
    exe_enable = 1'b0;
    chk("post_rst_seq", out_seq, 0);
    chk("post_rst_pc", out_pc, 32'h500);

    // sync_clear wins over a push in the same cycle.
    sync_clear = 1'b1; exe_enable = 1'b1; PC_in = 32'h600; IR_in = 32'h66;
    cyc();
    sync_clear = 1'b0; exe_enable = 1'b0;
    chk("sclr_valid", out_valid, 0);
    chk("sclr_fill", fill_level, 0);
    chk("sclr_drop", drop_count, 0);
    exe_enable = 1'b1; PC_in = 32'h700; IR_in = 32'h77;
    cyc();
    exe_enable = 1'b0;
    chk("sclr_next_seq", out_seq, 0);
    chk("sclr_next_ir", out_ir, 32'h77);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
